probe_capture_core: RTL and testbench
=====================================

Name: probe_capture_core

Overview:
- Parametrised on-chip logic-analyser capture engine, successor to the fixed 14-probe single-clock analyser core.
- Samples a probe bus of PROBE_W bits every sys_clk into a circular buffer DEPTH deep.
- Per-bit masked level/edge trigger, programmable pre-trigger depth, force/abort controls.
- After capture, a linearised read port presents samples oldest-first; the trigger sample sits at index pretrig. Sits between debug probes and the JTAG control/readout logic.

Parameters:
- PROBE_W, 14, probe bus width (1..256).
- DEPTH, 1024, capture samples; power of two, >= 4.
- ADDR_W, 10, log2(DEPTH).

Ports:
- sys_clk  in  1  capture and control clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- probe_i  in  PROBE_W  probe bus.
- arm_i  in  1  start pulse; honoured in IDLE or DONE only.
- abort_i  in  1  return to IDLE from any state.
- force_trig_i  in  1  unconditional trigger; honoured in WAIT_TRIG only.
- trig_mask_i  in  PROBE_W  1 = bit participates in trigger.
- trig_value_i  in  PROBE_W  required level / edge target per bit.
- trig_edge_i  in  PROBE_W  0 = level compare, 1 = transition into trig_value.
- pretrig_i  in  ADDR_W  samples stored before the trigger sample.
- armed_o  out  1  high in PRE or WAIT_TRIG.
- triggered_o  out  1  high in POST or DONE.
- done_o  out  1  high in DONE.
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_W  logical index; 0 = oldest sample.
- rd_data_o  out  PROBE_W  sample at start_ptr + rd_addr_i (mod DEPTH).
- rd_valid_o  out  1  rd_data_o valid; exactly 1 cycle after rd_en_i.

Behaviour:
- **Reset:** state IDLE; armed_o, triggered_o, done_o, rd_valid_o, rd_data_o = 0; pointers and counters = 0. Buffer RAM is not reset.
- **Arm:**
  - arm_i in IDLE/DONE latches mask, value, edge and pretrig into config registers, clears done_o, sets wptr = 0, and enters PRE next cycle.
  - arm_i is ignored in other states.
  - pretrig is clamped to DEPTH-1; the clamp is a no-op when ADDR_W = log2(DEPTH).
- **Capture:** every cycle in PRE, WAIT_TRIG or POST, probe_i is written to ram[wptr]; wptr increments mod DEPTH.
- **Edge history:** a prev register holds the last written sample. On the first capture cycle, prev = current sample, so no edge is detected.
- **PRE:**
  - Counts written samples.
  - After pretrig samples, moves to WAIT_TRIG; if pretrig = 0, moves from arm directly to WAIT_TRIG.
  - The trigger is not evaluated in PRE.
- **Trigger condition:** for every bit i with mask = 1:
  - edge = 0: probe[i] == value[i].
  - edge = 1: probe[i] == value[i] and prev[i] != value[i].
  - All masked bits must hold simultaneously; mask all-zero = true.
  - force_trig_i ORs in.
- **WAIT_TRIG:**
  - The trigger is evaluated on the sample being written that cycle. That sample is the trigger sample.
  - On trigger: trig_addr = wptr, start_ptr = trig_addr - pretrig (mod DEPTH), post_cnt = DEPTH-1-pretrig.
  - Next state is POST, or DONE if post_cnt = 0.
- **POST:** writes post_cnt further samples, then enters DONE. Total DEPTH samples, no gaps.
- **DONE:** writes stop and the buffer is frozen until the next arm.
- **abort_i:**
  - From any state, next cycle = IDLE; armed_o, triggered_o, done_o = 0.
  - abort_i has priority over arm_i and any trigger in the same cycle.
- **Read:**
  - Synchronous, 1-cycle latency; usable in any state, data defined only while done_o = 1.
  - rd_valid_o = registered rd_en_i.
  - Physical address = start_ptr + rd_addr_i, ADDR_W-bit wrap.
  - A read concurrent with an arm returns the old buffer content.
- **Reset mid-operation:** immediate IDLE. Buffer contents are undefined for readout until a new capture completes.

Test Plan (PROBE_W=8, DEPTH=16, ADDR_W=4; probe_i = free-running 8-bit counter, 0x00 on first capture cycle):
- Level trigger, mask=0xFF, value=0x5A, edge=0, pretrig=4, arm -> triggered_o on the cycle after sample 0x5A is written. Then done_o. Reads:
  - rd 0 = 0x56, rd 4 = 0x5A, rd 15 = 0x65.
  - rd_valid_o 1 cycle after each rd_en_i.
- Edge trigger, mask=0x01, edge=0x01, value=0x01, probe bit0 held 1 at arm, then 0 for 5 cycles, then 1 -> no trigger while initially high; triggers on the 0->1 sample, which appears at rd 4 (pretrig=4).
- pretrig=0 -> trigger sample at rd 0. pretrig=15 -> DONE on the cycle after trigger, with no POST cycles; trigger sample at rd 15.
- mask=0x00, pretrig=2 -> triggers on first WAIT_TRIG sample 0x02, so rd 2 = 0x02. Separately, mask=0xFF, value=0xEE never matched, force_trig_i pulsed at sample 0x30 -> rd 2 = 0x30.
- abort_i during POST -> IDLE next cycle, all flags 0. arm_i in the same cycle as abort is ignored. A subsequent re-arm completes normally.
- sys_rst_n low mid-WAIT_TRIG -> all outputs 0 asynchronously. After release, arm_i in POST is ignored, and arm_i in DONE restarts capture.

Source files
------------

// File: rtl/probe_capture_core.sv
// probe_capture_core
//   Logic-analyser capture engine. Samples a PROBE_W-bit probe bus into a
//   DEPTH-deep circular buffer, with a masked level/edge trigger, a
//   programmable pre-trigger depth, and force/abort controls. Once capture
//   is done, the read port returns samples oldest-first. The trigger sample
//   sits at logical index pretrig.
//
// Ports
//   sys_clk, sys_rst_n    clock, asynchronous active-low reset
//   probe_i               probe bus, captured every cycle in PRE/WAIT_TRIG/POST
//   arm_i                 start capture (honoured in IDLE or DONE)
//   abort_i               back to IDLE from any state (beats arm and trigger)
//   force_trig_i          unconditional trigger (honoured in WAIT_TRIG)
//   trig_mask_i           1 = bit takes part in the trigger
//   trig_value_i          required level / edge target per bit
//   trig_edge_i           0 = level match, 1 = transition into trig_value
//   pretrig_i             samples kept before the trigger sample
//   armed_o               PRE or WAIT_TRIG
//   triggered_o           POST or DONE
//   done_o                DONE
//   rd_en_i, rd_addr_i    read request, logical index (0 = oldest)
//   rd_data_o, rd_valid_o read data and its valid, one cycle after rd_en_i
//   state_o               FSM state, for debug observation
//
// Read handshake: rd_en_i is a single-cycle request with no back-pressure.
// rd_valid_o is rd_en_i delayed by one cycle, and rd_data_o is meaningful
// only in the cycle where rd_valid_o is high.
module probe_capture_core #(
   parameter int PROBE_W = 14,
   parameter int DEPTH   = 1024,
   parameter int ADDR_W  = 10
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [PROBE_W-1:0] probe_i,
   input  logic               arm_i,
   input  logic               abort_i,
   input  logic               force_trig_i,
   input  logic [PROBE_W-1:0] trig_mask_i,
   input  logic [PROBE_W-1:0] trig_value_i,
   input  logic [PROBE_W-1:0] trig_edge_i,
   input  logic [ADDR_W-1:0]  pretrig_i,
   output logic               armed_o,
   output logic               triggered_o,
   output logic               done_o,
   input  logic               rd_en_i,
   input  logic [ADDR_W-1:0]  rd_addr_i,
   output logic [PROBE_W-1:0] rd_data_o,
   output logic               rd_valid_o,
   output logic [2:0]         state_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_WAIT = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [ADDR_W:0] LP_MAX_PRE = (ADDR_W+1)'(DEPTH - 1);

   state_t              r_state, w_next;
   logic [ADDR_W-1:0]   r_wptr, r_pre_cnt, r_post_cnt, r_start_ptr, r_pretrig;
   logic [PROBE_W-1:0]  r_mask, r_value, r_edge, r_prev;
   logic                r_first;
   logic [PROBE_W-1:0]  r_ram [DEPTH];
   logic [PROBE_W-1:0]  r_rd_data;
   logic                r_rd_valid;

   logic                w_capture, w_arm_ok, w_fire, w_trig;
   logic [ADDR_W-1:0]   w_pretrig_clamped, w_post_init, w_rd_phys;
   logic [PROBE_W-1:0]  w_prev_eff, w_bit_ok;

   // The clamp only does something when ADDR_W is wider than log2(DEPTH).
   assign w_pretrig_clamped = ({1'b0, pretrig_i} > LP_MAX_PRE) ?
                              LP_MAX_PRE[ADDR_W-1:0] : pretrig_i;
   assign w_post_init = LP_MAX_PRE[ADDR_W-1:0] - r_pretrig;

   assign w_capture = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
   assign w_arm_ok  = arm_i && !abort_i && ((r_state == S_IDLE) || (r_state == S_DONE));

   // On the first capture cycle there is no previous sample yet. Treating
   // the current sample as "previous" ensures no edge can fire there.
   assign w_prev_eff = r_first ? probe_i : r_prev;

   // Per bit: unmasked bits pass. A masked bit must equal the target, and an
   // edge bit must also have differed from the target on the previous sample.
   assign w_bit_ok = ~r_mask | ((probe_i ~^ r_value) & (~r_edge | (w_prev_eff ^ r_value)));
   assign w_trig   = (&w_bit_ok) | force_trig_i;
   assign w_fire   = (r_state == S_WAIT) && w_trig && !abort_i;

   assign w_rd_phys = r_start_ptr + rd_addr_i;

   // State register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      if (abort_i) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: if (arm_i) w_next = (w_pretrig_clamped == '0) ? S_WAIT : S_PRE;
            S_PRE:          if (r_pre_cnt + 1'b1 == r_pretrig) w_next = S_WAIT;
            S_WAIT:         if (w_trig) w_next = (w_post_init == '0) ? S_DONE : S_POST;
            S_POST:         if (r_post_cnt == ADDR_W'(1)) w_next = S_DONE;
            default:        w_next = S_IDLE;
         endcase
      end
   end

   // Pointers, counters and latched trigger configuration
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wptr      <= '0;
         r_pre_cnt   <= '0;
         r_post_cnt  <= '0;
         r_start_ptr <= '0;
         r_pretrig   <= '0;
         r_mask      <= '0;
         r_value     <= '0;
         r_edge      <= '0;
         r_prev      <= '0;
         r_first     <= 1'b0;
      end else begin
         if (w_capture) begin
            r_wptr  <= r_wptr + 1'b1;
            r_prev  <= probe_i;
            r_first <= 1'b0;
         end
         if (r_state == S_PRE) r_pre_cnt <= r_pre_cnt + 1'b1;
         if (r_state == S_POST) r_post_cnt <= r_post_cnt - 1'b1;
         if (w_fire) begin
            // The sample being written now sits at r_wptr. The window
            // starts pretrig samples earlier.
            r_start_ptr <= r_wptr - r_pretrig;
            r_post_cnt  <= w_post_init;
         end
         if (w_arm_ok) begin
            r_mask    <= trig_mask_i;
            r_value   <= trig_value_i;
            r_edge    <= trig_edge_i;
            r_pretrig <= w_pretrig_clamped;
            r_wptr    <= '0;
            r_pre_cnt <= '0;
            r_first   <= 1'b1;
         end
      end
   end

   // Capture buffer, deliberately not reset
   always_ff @(posedge sys_clk) begin
      if (w_capture) r_ram[r_wptr] <= probe_i;
   end

   // Registered read port. r_start_ptr holds its value across an arm, so a
   // read issued in the arm cycle still returns the previous capture.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= rd_en_i;
         if (rd_en_i) r_rd_data <= r_ram[w_rd_phys];
      end
   end

   assign armed_o     = (r_state == S_PRE) || (r_state == S_WAIT);
   assign triggered_o = (r_state == S_POST) || (r_state == S_DONE);
   assign done_o      = (r_state == S_DONE);
   assign rd_data_o   = r_rd_data;
   assign rd_valid_o  = r_rd_valid;
   assign state_o     = r_state;

endmodule

// File: tb/tb_probe_capture_core.sv
// Directed bench for probe_capture_core (PROBE_W=8, DEPTH=16, ADDR_W=4).
// Each read pushes its expected sample into exp_q, and a monitor pops and
// compares whenever rd_valid_o is high. Flag checks are made inline.
module tb_probe_capture_core;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] probe_i;
  logic       arm_i, abort_i, force_trig_i;
  logic [7:0] trig_mask_i, trig_value_i, trig_edge_i;
  logic [3:0] pretrig_i;
  logic       armed_o, triggered_o, done_o;
  logic       rd_en_i;
  logic [3:0] rd_addr_i;
  logic [7:0] rd_data_o;
  logic       rd_valid_o;
  logic [2:0] state_o;

  logic [7:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  probe_capture_core #(.PROBE_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .probe_i(probe_i),
    .arm_i(arm_i), .abort_i(abort_i), .force_trig_i(force_trig_i),
    .trig_mask_i(trig_mask_i), .trig_value_i(trig_value_i),
    .trig_edge_i(trig_edge_i), .pretrig_i(pretrig_i),
    .armed_o(armed_o), .triggered_o(triggered_o), .done_o(done_o),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .state_o(state_o)
  );

  // clock
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // inputs change on the falling edge, outputs are sampled there too
  task automatic step();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic arm_cfg(input logic [7:0] m, input logic [7:0] v,
                         input logic [7:0] e, input logic [3:0] p);
    trig_mask_i  = m;
    trig_value_i = v;
    trig_edge_i  = e;
    pretrig_i    = p;
    arm_i        = 1'b1;
    step();
    arm_i = 1'b0;
    chk("armed_after_arm", armed_o, 1);
    chk("done_clear_after_arm", done_o, 0);
  endtask

  task automatic rd(input logic [3:0] addr, input logic [7:0] exp);
    rd_en_i   = 1'b1;
    rd_addr_i = addr;
    exp_q.push_back(exp);
    step();
    rd_en_i = 1'b0;
    chk("rd_valid_latency", rd_valid_o, 1);
  endtask

  // scoreboard monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge sys_clk);
      if (rd_valid_o) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rd_unexpected: got valid data 0x%0h, required no valid", rd_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("rd_data", rd_data_o, e);
        end
      end
    end
  end

  initial begin
    logic b;
    probe_i = 0; arm_i = 0; abort_i = 0; force_trig_i = 0;
    trig_mask_i = 0; trig_value_i = 0; trig_edge_i = 0; pretrig_i = 0;
    rd_en_i = 0; rd_addr_i = 0;
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_armed", armed_o, 0);
    chk("rst_triggered", triggered_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    sys_rst_n = 1'b1;
    step();

    // level trigger on 0x5A, pretrig 4
    arm_cfg(8'hFF, 8'h5A, 8'h00, 4'd4);
    for (int k = 0; k <= 8'h65; k++) begin
      probe_i = k[7:0];
      step();
      if (k == 8'h59) chk("t1_trig_before", triggered_o, 0);
      if (k == 8'h5A) chk("t1_trig_at", triggered_o, 1);
      if (k == 8'h64) chk("t1_done_before", done_o, 0);
      if (k == 8'h65) chk("t1_done", done_o, 1);
    end
    rd(4'd0, 8'h56);
    rd(4'd4, 8'h5A);
    rd(4'd15, 8'h65);

    // rising edge on bit0, bit0 high at arm, pretrig 4
    arm_cfg(8'h01, 8'h01, 8'h01, 4'd4);
    for (int s = 0; s <= 22; s++) begin
      b = (s <= 5) ? 1'b1 : (s <= 10) ? 1'b0 : 1'b1;
      probe_i = {s[6:0], b};
      step();
      if (s == 5)  chk("t2_no_trig_high", triggered_o, 0);
      if (s == 10) chk("t2_trig_before", triggered_o, 0);
      if (s == 11) chk("t2_trig_at", triggered_o, 1);
      if (s == 22) chk("t2_done", done_o, 1);
    end
    rd(4'd4, 8'h17);
    rd(4'd0, 8'h0E);
    rd(4'd15, 8'h2D);

    // falling edge on bit0, pretrig 0. The stale history from the previous
    // run has bit0 = 1, so the first sample must not look like an edge.
    arm_cfg(8'h01, 8'h00, 8'h01, 4'd0);
    for (int s = 0; s <= 18; s++) begin
      b = (s == 2) ? 1'b1 : 1'b0;
      probe_i = {s[6:0], b};
      step();
      if (s == 0)  chk("t3_first_no_edge", triggered_o, 0);
      if (s == 2)  chk("t3_trig_before", triggered_o, 0);
      if (s == 3)  chk("t3_trig_at", triggered_o, 1);
      if (s == 17) chk("t3_done_before", done_o, 0);
      if (s == 18) chk("t3_done", done_o, 1);
    end
    rd(4'd0, 8'h06);
    rd(4'd1, 8'h08);
    rd(4'd15, 8'h24);

    // pretrig 15: DONE directly on trigger, buffer frozen afterwards
    arm_cfg(8'hFF, 8'h20, 8'h00, 4'd15);
    for (int k = 0; k <= 8'h20; k++) begin
      probe_i = k[7:0];
      step();
      if (k == 8'h1F) chk("t4_trig_before", triggered_o, 0);
      if (k == 8'h20) begin
        chk("t4_trig_at", triggered_o, 1);
        chk("t4_done_no_post", done_o, 1);
      end
    end
    probe_i = 8'hFF;
    repeat (3) step();
    chk("t4_done_hold", done_o, 1);
    rd(4'd15, 8'h20);
    rd(4'd0, 8'h11);

    // mask all zero, pretrig 2
    arm_cfg(8'h00, 8'h00, 8'h00, 4'd2);
    for (int k = 0; k <= 15; k++) begin
      probe_i = k[7:0];
      step();
      if (k == 1)  chk("t5_trig_before", triggered_o, 0);
      if (k == 2)  chk("t5_trig_at", triggered_o, 1);
      if (k == 14) chk("t5_done_before", done_o, 0);
      if (k == 15) chk("t5_done", done_o, 1);
    end
    rd(4'd2, 8'h02);
    rd(4'd0, 8'h00);
    rd(4'd15, 8'h0F);

    // force trigger, with an extra force pulse in PRE that must be ignored
    arm_cfg(8'hFF, 8'hEE, 8'h00, 4'd2);
    for (int k = 0; k <= 8'h3D; k++) begin
      probe_i = k[7:0];
      force_trig_i = (k == 0) || (k == 8'h30);
      step();
      force_trig_i = 1'b0;
      if (k == 0)     chk("t6_force_in_pre", triggered_o, 0);
      if (k == 8'h2F) chk("t6_trig_before", triggered_o, 0);
      if (k == 8'h30) chk("t6_trig_at", triggered_o, 1);
      if (k == 8'h3D) chk("t6_done", done_o, 1);
    end
    rd(4'd2, 8'h30);
    rd(4'd0, 8'h2E);
    rd(4'd15, 8'h3D);

    // abort in POST together with arm
    arm_cfg(8'hFF, 8'h10, 8'h00, 4'd4);
    for (int k = 0; k <= 8'h14; k++) begin
      probe_i = k[7:0];
      if (k == 8'h14) begin
        abort_i = 1'b1;
        arm_i   = 1'b1;
      end
      step();
      abort_i = 1'b0;
      arm_i   = 1'b0;
      if (k == 8'h10) chk("t7_trig_at", triggered_o, 1);
    end
    chk("t7_abort_armed", armed_o, 0);
    chk("t7_abort_triggered", triggered_o, 0);
    chk("t7_abort_done", done_o, 0);
    step();
    chk("t7_arm_ignored", armed_o, 0);
    arm_cfg(8'hFF, 8'h03, 8'h00, 4'd1);
    for (int k = 0; k <= 17; k++) begin
      probe_i = k[7:0];
      step();
      if (k == 3)  chk("t7_rearm_trig", triggered_o, 1);
      if (k == 16) chk("t7_rearm_done_before", done_o, 0);
      if (k == 17) chk("t7_rearm_done", done_o, 1);
    end
    rd(4'd0, 8'h02);
    rd(4'd1, 8'h03);
    rd(4'd15, 8'h11);

    // asynchronous reset in WAIT_TRIG
    arm_cfg(8'hFF, 8'hEE, 8'h00, 4'd2);
    for (int k = 0; k <= 8; k++) begin
      probe_i = k[7:0];
      step();
    end
    chk("t8_armed_pre_rst", armed_o, 1);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("t8_rst_armed", armed_o, 0);
    chk("t8_rst_triggered", triggered_o, 0);
    chk("t8_rst_done", done_o, 0);
    chk("t8_rst_rd_valid", rd_valid_o, 0);
    chk("t8_rst_rd_data", rd_data_o, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step();
    arm_cfg(8'hFF, 8'h05, 8'h00, 4'd3);
    for (int k = 0; k <= 17; k++) begin
      probe_i = k[7:0];
      if (k == 7) arm_i = 1'b1;
      step();
      arm_i = 1'b0;
      if (k == 5)  chk("t8_trig_at", triggered_o, 1);
      if (k == 7) begin
        chk("t8_arm_in_post_trig", triggered_o, 1);
        chk("t8_arm_in_post_armed", armed_o, 0);
      end
      if (k == 16) chk("t8_done_before", done_o, 0);
      if (k == 17) chk("t8_done", done_o, 1);
    end
    // arm from DONE with a concurrent read that must see the old capture
    rd_en_i   = 1'b1;
    rd_addr_i = 4'd0;
    exp_q.push_back(8'h02);
    arm_cfg(8'hFF, 8'h04, 8'h00, 4'd0);
    rd_en_i = 1'b0;
    for (int k = 0; k <= 19; k++) begin
      probe_i = k[7:0];
      step();
      if (k == 4)  chk("t8_rearm_trig", triggered_o, 1);
      if (k == 19) chk("t8_rearm_done", done_o, 1);
    end
    rd(4'd0, 8'h04);
    rd(4'd15, 8'h13);

    repeat (2) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
